// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: r200 branch condition, target and mispredict resolution behind one registered valid/ready stage
// Ports: clk, rst (sync, active-high); flush drops the held result and blocks input for the cycle;
//   in_valid/in_ready request with in_rs1, in_rs2, in_funct3, in_pc, in_imm, in_pred_taken;
//   out_valid/out_ready result with out_taken, out_next_pc, out_mispredict, out_illegal.
// Define BRANCH_STATS_EN to add stat_branches, stat_taken, stat_mispredicts (CNTW-bit, counted at acceptance).
module branch_resolve_unit #(
  parameter int XLEN = 32,
  parameter int IMMW = 13,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [IMMW-1:0] in_imm,
  input  logic            in_pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_next_pc,
  output logic            out_mispredict,
  output logic            out_illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNTW-1:0] stat_branches,
  output logic [CNTW-1:0] stat_taken,
  output logic [CNTW-1:0] stat_mispredicts
`endif
);
  if (XLEN < 8 || IMMW < 2 || IMMW > XLEN || CNTW < 1) begin : g_param_check
    $error("branch_resolve_unit: unsupported parameter set");
  end
  logic eq, lt, ltu, base, illegal, taken, mispredict, accept;
  logic [XLEN-1:0] next_pc;
  always_comb begin
    eq = in_rs1 == in_rs2;
    lt = $signed(in_rs1) < $signed(in_rs2);
    ltu = in_rs1 < in_rs2;
    // funct3[2:1] picks the base compare, funct3[0] inverts it; 01x is the illegal hole
    base = in_funct3[2] ? (in_funct3[1] ? ltu : lt) : eq;
    illegal = in_funct3[2:1] == 2'b01;
    taken = !illegal && (base ^ in_funct3[0]);
    mispredict = taken ^ in_pred_taken;
    next_pc = taken ? in_pc + XLEN'($signed(in_imm)) : in_pc + XLEN'(4);
  end
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_taken <= 1'b0;
      out_next_pc <= '0;
      out_mispredict <= 1'b0;
      out_illegal <= 1'b0;
    end else begin
      out_valid <= accept || (out_valid && !out_ready && !flush);
      if (accept) begin
        out_taken <= taken;
        out_next_pc <= next_pc;
        out_mispredict <= mispredict;
        out_illegal <= illegal;
      end
    end
  end
`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches <= '0;
      stat_taken <= '0;
      stat_mispredicts <= '0;
    end else if (accept) begin
      stat_branches <= stat_branches + CNTW'(1);
      stat_taken <= stat_taken + CNTW'(taken);
      stat_mispredicts <= stat_mispredicts + CNTW'(mispredict);
    end
  end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench for branch_resolve_unit
module tb_branch_resolve_unit;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_ready;
  logic [31:0] in_rs1 = '0, in_rs2 = '0, in_pc = '0;
  logic [2:0] in_funct3 = '0;
  logic [12:0] in_imm = '0;
  logic in_pred_taken = 1'b0, out_valid, out_ready = 1'b1;
  logic out_taken, out_mispredict, out_illegal;
  logic [31:0] out_next_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_mispredicts;
`endif
  int n_cmp = 0, n_bad = 0;
  int sb_br = 0, sb_tk = 0, sb_mp = 0;
  typedef struct packed {logic t; logic [31:0] pc; logic m; logic i;} exp_t;
  exp_t sb[$];
  exp_t e, hold;
  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3), .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_next_pc(out_next_pc), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_taken(stat_taken), .stat_mispredicts(stat_mispredicts)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                 input logic [31:0] pc, input logic [12:0] imm, input logic p);
    exp_t r;
    logic c;
    case (f)
      3'b000: c = a == b;
      3'b001: c = a != b;
      3'b100: c = $signed(a) < $signed(b);
      3'b101: c = $signed(a) >= $signed(b);
      3'b110: c = a < b;
      3'b111: c = a >= b;
      default: c = 1'b0;
    endcase
    r.t = c;
    r.pc = c ? pc + {{19{imm[12]}}, imm} : pc + 32'd4;
    r.m = c ^ p;
    r.i = (f == 3'b010) || (f == 3'b011);
    return r;
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      sb_br = 0; sb_tk = 0; sb_mp = 0;
    end else begin
      if (out_valid && flush) begin
        if (sb.size() > 0) void'(sb.pop_front());
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          e = sb.pop_front();
          chk("taken", out_taken, e.t);
          chk("next_pc", out_next_pc, e.pc);
          chk("mispredict", out_mispredict, e.m);
          chk("illegal", out_illegal, e.i);
        end
      end
      if (in_valid && in_ready) begin
        e = model(in_rs1, in_rs2, in_funct3, in_pc, in_imm, in_pred_taken);
        sb.push_back(e);
        sb_br++; sb_tk += int'(e.t); sb_mp += int'(e.m);
      end
    end
  end
  task automatic set_in(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                        input logic [31:0] pc, input logic [12:0] imm, input logic p);
    in_rs1 = a; in_rs2 = b; in_funct3 = f; in_pc = pc; in_imm = imm; in_pred_taken = p;
    in_valid = 1'b1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                      input logic [31:0] pc, input logic [12:0] imm, input logic p);
    logic ok;
    int n;
    set_in(a, b, f, pc, imm, p);
    n = 0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) break;
      n++;
      if (n >= 2) out_ready = 1'b1;
      if (n > 40) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_taken"}, out_taken, 0);
    chk({tag, "_next_pc"}, out_next_pc, 0);
    chk({tag, "_mispredict"}, out_mispredict, 0);
    chk({tag, "_illegal"}, out_illegal, 0);
  endtask
  initial begin
    logic [2:0] f;
    logic [31:0] a;
    int n;
    set_in(32'd5, 32'd5, 3'b000, 32'h40, 13'd16, 1'b1);
    repeat (2) step();
    chk_zero("reset");
    rst = 1'b0;
    step();
    chk("latency_valid", out_valid, 1);
    chk("first_next_pc", out_next_pc, 32'h50);
    in_valid = 1'b0;
    send(32'hFFFF_FFFF, 32'd1, 3'b100, 32'h100, 13'h1FF8, 1'b0);
    send(32'hFFFF_FFFF, 32'd1, 3'b110, 32'h100, 13'h1FF8, 1'b0);
    send(32'h1234, 32'h1234, 3'b000, 32'hFFFF_FFFC, 13'd8, 1'b0);
    send(32'd1, 32'd1, 3'b010, 32'h200, 13'd64, 1'b1);
    send(32'd3, 32'd9, 3'b011, 32'h300, 13'd32, 1'b0);
    in_valid = 1'b0;
    step();
    // backpressure: one result held for three cycles while the next request waits
    out_ready = 1'b0;
    send(32'd7, 32'd8, 3'b101, 32'h400, 13'h1FF0, 1'b1);
    hold = model(32'd7, 32'd8, 3'b101, 32'h400, 13'h1FF0, 1'b1);
    set_in(32'd2, 32'd3, 3'b001, 32'h500, 13'd20, 1'b1);
    repeat (3) begin
      step();
      chk("hold_in_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_next_pc", out_next_pc, hold.pc);
      chk("hold_taken", out_taken, hold.t);
    end
    out_ready = 1'b1;
    send(32'd2, 32'd3, 3'b001, 32'h500, 13'd20, 1'b1);
    send(32'd9, 32'd2, 3'b111, 32'h600, 13'd12, 1'b0);
    send(32'd9, 32'd9, 3'b001, 32'h700, 13'd12, 1'b1);
    in_valid = 1'b0;
    step();
    // flush with a held result and a pending request
    out_ready = 1'b0;
    send(32'd1, 32'd2, 3'b100, 32'h800, 13'd40, 1'b0);
    set_in(32'd4, 32'd4, 3'b000, 32'h900, 13'd44, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    chk("flush_valid", out_valid, 0);
`ifdef BRANCH_STATS_EN
    chk("flush_stat_branches", stat_branches, sb_br);
`endif
    out_ready = 1'b1;
    send(32'd4, 32'd4, 3'b000, 32'h900, 13'd44, 1'b0);
    in_valid = 1'b0;
    // randomized traffic with random backpressure
    for (int k = 0; k < 24; k++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      send(a, ($urandom_range(0, 2) == 0) ? a : $urandom, f, $urandom & 32'hFFFF_FFFC,
           13'($urandom) & 13'h1FFE, 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
`ifdef BRANCH_STATS_EN
    chk("stat_branches", stat_branches, sb_br);
    chk("stat_taken", stat_taken, sb_tk);
    chk("stat_mispredicts", stat_mispredicts, sb_mp);
`endif
    // reset while a result is held
    out_ready = 1'b0;
    send(32'd1, 32'd1, 3'b000, 32'hA00, 13'd8, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("midreset");
`ifdef BRANCH_STATS_EN
    chk("midreset_stat", stat_branches, 0);
`endif
    out_ready = 1'b1;
    send(32'd5, 32'd6, 3'b110, 32'hB00, 13'd100, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised branch resolution stage for the r200 core.
- Compares two XLEN-wide register operands and selects the branch condition from funct3.
- Computes the branch target and the fall-through PC, then checks the outcome against the front-end prediction.
- One registered output stage with a valid/ready handshake on both sides, plus a flush input; sits between execute operand fetch and the fetch redirect logic.

Parameters:
- XLEN, 32, operand and PC width in bits (≥ 8).
- IMMW, 13, branch immediate width (signed, byte offset, bit 0 always 0).
- CNTW, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  kill: drop the held result and refuse new input this cycle.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_rs1  in  XLEN  first operand.
- in_rs2  in  XLEN  second operand.
- in_funct3  in  3  condition select.
- in_pc  in  XLEN  branch instruction PC.
- in_imm  in  IMMW  signed branch offset.
- in_pred_taken  in  1  front-end prediction.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_taken  out  1  resolved direction.
- out_next_pc  out  XLEN  correct next PC.
- out_mispredict  out  1  out_taken != prediction.
- out_illegal  out  1  funct3 was 010 or 011.

Behaviour:
- Reset: out_valid=0, out_taken=0, out_next_pc=0, out_mispredict=0, out_illegal=0; counters 0.
- Conditions are computed combinationally from in_rs1/in_rs2:
  - eq: rs1 == rs2.
  - ne: !eq.
  - lt: signed rs1 < rs2.
  - ge: !lt.
  - ltu: unsigned rs1 < rs2.
  - geu: !ltu.
- Condition select by funct3: 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
- funct3 010/011: taken forced to 0 and illegal=1. Never aliased to eq.
- Target: in_pc + sign-extend(in_imm) to XLEN, modulo 2^XLEN (wraps, no overflow flag).
- Fall-through: in_pc + 4, modulo 2^XLEN.
- next_pc = taken ? target : fall-through.
- mispredict = taken XOR in_pred_taken. An illegal request reports mispredict = in_pred_taken.
- in_ready = !flush && (!out_valid || out_ready).
- Accept when in_valid && in_ready. Results are registered and out_valid=1 on the next edge, so latency is exactly 1 cycle.
- Output hold: while out_valid && !out_ready, all out_* stay stable and in_ready=0.
- Simultaneous drain and accept (out_valid && out_ready && in_valid): the new result replaces the old one, out_valid stays 1, giving full throughput of 1 per cycle.
- Drain without new input: out_valid -> 0 on the next edge. out_taken, out_next_pc, out_mispredict and out_illegal hold their last values; consumers must not rely on them.
- flush=1: out_valid -> 0 on the next edge and no input is accepted, regardless of in_valid and out_ready. Flush and rst in the same cycle behave as rst.
- rst mid-operation: the held result is discarded and all outputs return to reset values on the next edge.
- in_* are sampled only at acceptance. Changes while in_ready=0 have no effect.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- With the macro defined, three extra output ports are added:
  - stat_branches (CNTW): increments on every accepted request.
  - stat_taken (CNTW): increments on every accepted request that resolves taken.
  - stat_mispredicts (CNTW): increments on every accepted request with mispredict=1.
- Counter rules:
  - All three wrap modulo 2^CNTW.
  - They count at acceptance, not at output, so a result killed by a later flush has already been counted.
  - They clear on rst.
  - They do not clear on flush.
- Without the macro: ports and counters are absent, and the core behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0 and all outputs 0. First accept occurs in the cycle after rst deasserts.
- Signed vs unsigned, funct3=100 then 110: rs1=0xFFFFFFFF, rs2=1 -> blt out_taken=1, bltu out_taken=0. With pc=0x100, imm=-8, pred=0, bltu gives next_pc=0x104 and mispredict=0.
- Target wrap: pc=0xFFFFFFFC, imm=+8, funct3=000, rs1=rs2 -> out_taken=1, out_next_pc=0x00000004. With pred=0, out_mispredict=1.
- Illegal funct3: funct3=010, pred=1 -> out_taken=0, out_illegal=1, out_mispredict=1, next_pc=pc+4.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Then out_ready=1 with a new request -> back-to-back results, one per cycle, none lost or duplicated.
- Flush: flush asserted with in_valid=1, out_valid=1, out_ready=0 -> next cycle out_valid=0 and the request is not accepted. With BRANCH_STATS_EN, stat_branches is unchanged by the flushed request and not reset by the flush.
